// File: rtl/pproc_bus_gba.sv
// Shared GBA register map: DirectSound FIFO addresses and SOUNDCNT_H bit positions,
// plus a small byte-select helper for the PCM path.
package pproc_bus_gba;

    localparam logic [27:0] FIFO_A_ADR = 28'h40000A0;
    localparam logic [27:0] FIFO_B_ADR = 28'h40000A4;

    localparam int SOUNDCNT_H_TIMER_A = 10;
    localparam int SOUNDCNT_H_RESET_A = 11;
    localparam int SOUNDCNT_H_TIMER_B = 14;
    localparam int SOUNDCNT_H_RESET_B = 15;

    typedef enum logic {
        FIFO_CH_A = 1'b0,
        FIFO_CH_B = 1'b1
    } fifo_ch_e;

    // Little-endian byte pick: idx 0 returns bits 7:0.
    function automatic logic [7:0] pcm_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gba_sound_fifo_mem.sv
// Word storage for one DirectSound FIFO: synchronous write, asynchronous read of the
// head word, with its own wrapping read/write pointers.
module gba_sound_fifo_mem #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic        i_rd_en,
    output logic [31:0] o_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/gba_sound_fifo.sv
// DirectSound FIFO channel: accepts 32-bit bus writes, emits one PCM byte per selected
// timer tick and requests a DMA refill as words drain.
module gba_sound_fifo
    import pproc_bus_gba::*;
#(
    parameter int          index         = 0,
    parameter logic [27:0] fifo_adr      = 28'h0,
    parameter int          depth_words   = 8,
    parameter int          dma_threshold = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           gb_on,
    input  logic [31:0]                    gb_bus_din,
    inout  wire  [31:0]                    gb_bus_dout,
    input  logic [27:0]                    gb_bus_adr,
    input  logic                           gb_bus_rnw,
    input  logic                           gb_bus_ena,
    input  logic [3:0]                     gb_bus_be,
    input  logic [1:0]                     gb_bus_acc,
    input  logic                           gb_bus_rst,
    output wire                            gb_bus_done,
    input  logic                           timer0_tick,
    input  logic                           timer1_tick,
    input  logic                           timer_select,
    input  logic                           fifo_reset,
    output logic [7:0]                     sample,
    output logic                           sample_valid,
    output logic                           dma_req,
    output logic [$clog2(depth_words):0]   fifo_level
);

    localparam int LVL_W = $clog2(depth_words) + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(depth_words);
    localparam logic [LVL_W-1:0] LVL_THR  = LVL_W'(dma_threshold);

    logic [LVL_W-1:0] r_level;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_sample;
    logic             r_sample_valid;
    logic             r_dma_req;

    logic             w_clear;
    logic             w_push;
    logic             w_tick;
    logic             w_pop_byte;
    logic             w_pop_word;
    logic             w_wr_en;
    logic [31:0]      w_head_word;
    logic [LVL_W-1:0] w_level_after_pop;
    logic             w_unused_inputs;

    // Register is write-only: the read bus and done strobe are never driven.
    assign gb_bus_dout = 'z;
    assign gb_bus_done = 1'bz;

    assign w_unused_inputs = ^{gb_bus_acc, gb_bus_rst, (index != 0)};

    assign w_clear    = reset | fifo_reset;
    assign w_push     = ~w_clear & gb_bus_ena & ~gb_bus_rnw &
                        (gb_bus_adr == fifo_adr) & (gb_bus_be == 4'hF);
    assign w_tick     = ~w_clear & gb_on & (timer_select ? timer1_tick : timer0_tick);
    assign w_pop_byte = w_tick & (r_level != '0);
    assign w_pop_word = w_pop_byte & (r_byte_idx == 2'd3);
    // A full FIFO still takes a word when the head is leaving on the same edge.
    assign w_wr_en    = w_push & ((r_level != LVL_FULL) | w_pop_word);

    assign w_level_after_pop = r_level - 1'b1;

    gba_sound_fifo_mem #(
        .DEPTH(depth_words)
    ) u_mem (
        .clk      (clk),
        .i_clear  (w_clear),
        .i_wr_en  (w_wr_en),
        .i_wr_data(gb_bus_din),
        .i_rd_en  (w_pop_word),
        .o_rd_data(w_head_word)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_level        <= '0;
            r_byte_idx     <= 2'd0;
            r_sample       <= 8'd0;
            r_sample_valid <= 1'b0;
            r_dma_req      <= 1'b0;
        end else begin
            r_sample_valid <= w_tick;
            r_dma_req      <= w_pop_word & (w_level_after_pop <= LVL_THR);
            if (w_pop_byte) begin
                r_sample   <= pcm_byte(w_head_word, r_byte_idx);
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            case ({w_wr_en, w_pop_word})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign dma_req      = r_dma_req;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_gba_sound_fifo.sv
// Self-checking bench for gba_sound_fifo: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the channel.
module tb_gba_sound_fifo;
    import pproc_bus_gba::*;

    localparam logic [27:0] ADR = FIFO_A_ADR;
    localparam int THR = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gb_on = 1'b1;
    logic [31:0] gb_bus_din = '0;
    wire  [31:0] gb_bus_dout;
    logic [27:0] gb_bus_adr = '0;
    logic        gb_bus_rnw = 1'b0;
    logic        gb_bus_ena = 1'b0;
    logic [3:0]  gb_bus_be = 4'h0;
    logic [1:0]  gb_bus_acc = 2'b10;
    logic        gb_bus_rst = 1'b0;
    wire         gb_bus_done;
    logic        timer0_tick = 1'b0;
    logic        timer1_tick = 1'b0;
    logic        timer_select = 1'b0;
    logic        fifo_reset = 1'b0;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        dma_req;
    logic [3:0]  fifo_level;

    gba_sound_fifo #(
        .index(0), .fifo_adr(ADR), .depth_words(DEPTH), .dma_threshold(THR)
    ) dut (
        .clk(clk), .reset(reset), .gb_on(gb_on), .gb_bus_din(gb_bus_din),
        .gb_bus_dout(gb_bus_dout), .gb_bus_adr(gb_bus_adr), .gb_bus_rnw(gb_bus_rnw),
        .gb_bus_ena(gb_bus_ena), .gb_bus_be(gb_bus_be), .gb_bus_acc(gb_bus_acc),
        .gb_bus_rst(gb_bus_rst), .gb_bus_done(gb_bus_done),
        .timer0_tick(timer0_tick), .timer1_tick(timer1_tick),
        .timer_select(timer_select), .fifo_reset(fifo_reset),
        .sample(sample), .sample_valid(sample_valid), .dma_req(dma_req),
        .fifo_level(fifo_level)
    );

    always #30 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_q[$];
    int          m_bidx = 0;
    logic [7:0]  m_sample = 8'd0;
    logic        m_valid = 1'b0;
    logic        m_dma = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural view: a word queue drained byte by byte, pop before push.
    task automatic model_edge();
        logic push, tick;
        logic [31:0] head;
        push = gb_bus_ena & ~gb_bus_rnw & (gb_bus_adr == ADR) & (gb_bus_be == 4'hF);
        tick = gb_on & (timer_select ? timer1_tick : timer0_tick);
        if (reset || fifo_reset) begin
            m_q.delete();
            m_bidx = 0; m_sample = 8'd0; m_valid = 1'b0; m_dma = 1'b0;
        end else begin
            m_valid = tick;
            m_dma = 1'b0;
            if (tick && m_q.size() > 0) begin
                head = m_q[0];
                m_sample = head[8*m_bidx +: 8];
                if (m_bidx == 3) begin
                    m_bidx = 0;
                    void'(m_q.pop_front());
                    m_dma = (m_q.size() <= THR);
                end else begin
                    m_bidx++;
                end
            end
            if (push && m_q.size() < DEPTH) m_q.push_back(gb_bus_din);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".sample"}, 32'(sample), 32'(m_sample));
        check({tag, ".valid"}, 32'(sample_valid), 32'(m_valid));
        check({tag, ".dma"}, 32'(dma_req), 32'(m_dma));
        check({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
        $display("%s: lvl=%0d sample=%02h v=%0b dma=%0b", tag, fifo_level, sample,
                 sample_valid, dma_req);
        reset = 1'b0; fifo_reset = 1'b0; gb_bus_ena = 1'b0;
        timer0_tick = 1'b0; timer1_tick = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] w);
        gb_bus_ena = 1'b1; gb_bus_rnw = 1'b0; gb_bus_adr = ADR; gb_bus_be = 4'hF;
        gb_bus_din = w;
    endtask

    task automatic push(input logic [31:0] w);
        set_push(w);
        cyc("push");
    endtask

    task automatic tick0(input int n);
        for (int i = 0; i < n; i++) begin
            timer0_tick = 1'b1;
            cyc("tick0");
        end
    endtask

    initial begin
        #1;
        reset = 1'b1;
        cyc("reset");

        // Basic drain
        push(32'h04030201);
        tick0(4);
        cyc("idle");

        // Overflow: ninth word dropped
        for (int i = 1; i <= 9; i++) push({8{i[3:0]}});
        tick0(33);

        // DMA threshold from full
        for (int i = 0; i < 8; i++) push($urandom);
        tick0(16);
        tick0(16);

        // Timer select and gb_on gating
        push(32'hA1B2C3D4);
        timer_select = 1'b1;
        timer0_tick = 1'b1; cyc("sel1_t0");
        timer1_tick = 1'b1; cyc("sel1_t1");
        gb_on = 1'b0;
        timer0_tick = 1'b1; cyc("off_t0");
        timer1_tick = 1'b1; cyc("off_t1");
        gb_on = 1'b1; timer_select = 1'b0;
        tick0(3);

        // Underrun and simultaneity
        tick0(2);
        for (int i = 0; i < 3; i++) push($urandom);
        tick0(3);
        set_push(32'h55667788); timer0_tick = 1'b1; cyc("push_pop_l3");
        tick0(12);
        set_push(32'hCAFEF00D); timer0_tick = 1'b1; cyc("push_tick_l0");
        tick0(4);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) push($urandom);
        tick0(2);
        set_push(32'hDEADBEEF); fifo_reset = 1'b1; timer0_tick = 1'b1; cyc("freset");
        push(32'h000000EE);
        tick0(1);

        // Ignored writes: partial byte enables, reads, wrong address
        gb_bus_ena = 1'b1; gb_bus_adr = ADR; gb_bus_be = 4'h7; gb_bus_din = 32'h1; cyc("be7");
        gb_bus_ena = 1'b1; gb_bus_adr = ADR; gb_bus_be = 4'hF; gb_bus_rnw = 1'b1; cyc("read");
        gb_bus_rnw = 1'b0;
        gb_bus_ena = 1'b1; gb_bus_adr = FIFO_B_ADR; gb_bus_be = 4'hF; cyc("wrong_adr");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            fifo_reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 99) < 35) begin
                gb_bus_ena = 1'b1;
                gb_bus_rnw = ($urandom_range(0, 9) == 0);
                gb_bus_adr = ($urandom_range(0, 9) == 0) ? FIFO_B_ADR : ADR;
                gb_bus_be  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                gb_bus_din = $urandom;
            end
            timer0_tick = ($urandom_range(0, 99) < 30);
            timer1_tick = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 49) == 0) timer_select = ~timer_select;
            gb_on = ($urandom_range(0, 19) != 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
